// File: rtl/bsg_dmc_pkg.sv
// Shared types for the DRAM controller clocking blocks.
//   bsg_dmc_clk_div_state_e : sequencer states of bsg_dmc_clk_div_gen.
//   safe_clog2              : ceil(log2(n)), never below 1, so that single-entry fields keep
//                             a one-bit width.
// The config struct (ch, ratio) depends on module parameters, so it is declared inside
// bsg_dmc_clk_div_gen itself.
package bsg_dmc_pkg;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StApply,
    StHold
  } bsg_dmc_clk_div_state_e;

  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_dmc_clk_div_ch.sv
// One divided-clock channel. The counter runs 0..ratio; on reaching ratio it wraps and the
// output clock toggles, giving a period of 2*(ratio+1) source cycles at 50% duty.
// Ports:
//   clk_i, reset_i : source clock, synchronous active-high reset
//   load_i         : load ratio_i, restart the counter and force the clock low
//   ratio_i        : ratio to load
//   clk_r_o        : registered divided clock
//   fall_o         : this cycle ends a high phase (clk_r_o falls at the next edge)
//   rise_o         : this cycle ends a low phase (clk_r_o rises at the next edge)
module bsg_dmc_clk_div_ch #(
  parameter int unsigned ratio_width_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     load_i,
  input  logic [ratio_width_p-1:0] ratio_i,
  output logic                     clk_r_o,
  output logic                     fall_o,
  output logic                     rise_o
);

  logic [ratio_width_p-1:0] ratio_q, ratio_d;
  logic [ratio_width_p-1:0] cnt_q, cnt_d;
  logic                     clk_r_q, clk_r_d;
  logic                     wrap;

  assign wrap = (cnt_q == ratio_q);

  always_comb begin
    ratio_d = ratio_q;
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    clk_r_d = wrap ? ~clk_r_q : clk_r_q;
    // Load is only issued in a falling-edge cycle, so forcing low here never cuts a phase.
    if (load_i) begin
      ratio_d = ratio_i;
      cnt_d   = '0;
      clk_r_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ratio_q <= '0;
      cnt_q   <= '0;
      clk_r_q <= 1'b0;
    end else begin
      ratio_q <= ratio_d;
      cnt_q   <= cnt_d;
      clk_r_q <= clk_r_d;
    end
  end

  assign clk_r_o = clk_r_q;
  assign fall_o  = wrap & clk_r_q;
  assign rise_o  = wrap & ~clk_r_q;

endmodule

// File: rtl/bsg_dmc_clk_div_gen.sv
// Multi-channel programmable clock divider with per-channel reset sequencing.
// Each channel runs a registered divided clock of clk_i; ratios may be changed at runtime.
// A ratio change is applied only at the end of the channel's high phase and then holds that
// channel's reset for rst_hold_cycles_p rising edges of its divided clock.
// Ports:
//   clk_i, reset_i : source clock, synchronous active-high reset
//   cfg_v_i        : config request valid (accepted when cfg_ready_o is high)
//   cfg_ch_i       : target channel
//   cfg_ratio_i    : new ratio R (period 2*(R+1) clk_i cycles)
//   cfg_ready_o    : sequencer idle, request will be accepted
//   cfg_err_o      : one-cycle pulse after an accepted request named a nonexistent channel
//   clk_r_o        : divided clocks
//   ch_reset_o     : per-channel resets, synchronous to clk_i
// Build option: define BSG_DMC_CLK_DIV_PHASE_ALIGN_EN to also require a channel 0 falling-edge
// cycle before loading any channel other than 0.
module bsg_dmc_clk_div_gen
  import bsg_dmc_pkg::*;
#(
  parameter int unsigned num_ch_p          = 2,
  parameter int unsigned ratio_width_p     = 4,
  parameter int unsigned rst_hold_cycles_p = 8
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              cfg_v_i,
  input  logic [safe_clog2(num_ch_p)-1:0]   cfg_ch_i,
  input  logic [ratio_width_p-1:0]          cfg_ratio_i,
  output logic                              cfg_ready_o,
  output logic                              cfg_err_o,
  output logic [num_ch_p-1:0]               clk_r_o,
  output logic [num_ch_p-1:0]               ch_reset_o
);

  localparam int unsigned ch_width_lp   = safe_clog2(num_ch_p);
  localparam int unsigned hold_width_lp = safe_clog2(rst_hold_cycles_p + 1);
  localparam logic [hold_width_lp-1:0] hold_last_lp = hold_width_lp'(rst_hold_cycles_p - 1);

  typedef struct packed {
    logic [ch_width_lp-1:0]   ch;
    logic [ratio_width_p-1:0] ratio;
  } bsg_dmc_clk_div_cfg_s;

  bsg_dmc_clk_div_state_e     state_q, state_d;
  bsg_dmc_clk_div_cfg_s       cfg_q, cfg_d;
  logic [hold_width_lp-1:0]   hold_cnt_q, hold_cnt_d;
  logic [num_ch_p-1:0]        ch_reset_q, ch_reset_d;
  logic                       cfg_err_q, cfg_err_d;

  logic [num_ch_p-1:0] fall, rise, load;
  logic                sel_fall, sel_rise, apply_ok, hold_done;

  for (genvar i = 0; i < num_ch_p; i++) begin : g_ch
    bsg_dmc_clk_div_ch #(
      .ratio_width_p(ratio_width_p)
    ) u_ch (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .load_i (load[i]),
      .ratio_i(cfg_q.ratio),
      .clk_r_o(clk_r_o[i]),
      .fall_o (fall[i]),
      .rise_o (rise[i])
    );
  end

  // Select the latched target channel's edge strobes without indexing past num_ch_p.
  always_comb begin
    sel_fall = 1'b0;
    sel_rise = 1'b0;
    for (int i = 0; i < num_ch_p; i++) begin
      if (cfg_q.ch == ch_width_lp'(i)) begin
        sel_fall = fall[i];
        sel_rise = rise[i];
      end
    end
  end

`ifdef BSG_DMC_CLK_DIV_PHASE_ALIGN_EN
  assign apply_ok = sel_fall & ((cfg_q.ch == '0) | fall[0]);
`else
  assign apply_ok = sel_fall;
`endif

  assign hold_done = (hold_cnt_q == hold_last_lp);

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    hold_cnt_d = hold_cnt_q;
    ch_reset_d = ch_reset_q;
    cfg_err_d  = 1'b0;
    load       = '0;
    unique case (state_q)
      StInit: begin
        if (rise[0]) begin
          if (hold_done) begin
            hold_cnt_d = '0;
            ch_reset_d = '0;
            state_d    = StIdle;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      StIdle: begin
        if (cfg_v_i) begin
          if (32'(cfg_ch_i) >= num_ch_p) begin
            cfg_err_d = 1'b1;
          end else begin
            cfg_d.ch    = cfg_ch_i;
            cfg_d.ratio = cfg_ratio_i;
            state_d     = StApply;
          end
        end
      end
      StApply: begin
        if (apply_ok) begin
          for (int i = 0; i < num_ch_p; i++) begin
            if (cfg_q.ch == ch_width_lp'(i)) begin
              load[i]       = 1'b1;
              ch_reset_d[i] = 1'b1;
            end
          end
          hold_cnt_d = '0;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (sel_rise) begin
          if (hold_done) begin
            for (int i = 0; i < num_ch_p; i++) begin
              if (cfg_q.ch == ch_width_lp'(i)) ch_reset_d[i] = 1'b0;
            end
            hold_cnt_d = '0;
            state_d    = StIdle;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StInit;
      cfg_q      <= '0;
      hold_cnt_q <= '0;
      ch_reset_q <= '1;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      hold_cnt_q <= hold_cnt_d;
      ch_reset_q <= ch_reset_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign cfg_ready_o = (state_q == StIdle);
  assign cfg_err_o   = cfg_err_q;
  assign ch_reset_o  = ch_reset_q;

endmodule
